// File: rtl/arm_ctrl_pkg.sv
// Shared constants, enums and the condition-code helper for the ARMv4-subset control unit.
package arm_ctrl_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_MOV = 4'b0100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10
    } state_t;

    // flags are {N,Z,C,V}; COND_NV never executes, it is the halt request
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond_t'(cond))
            COND_EQ: return z;
            COND_NE: return !z;
            COND_CS: return c;
            COND_CC: return !c;
            COND_MI: return n;
            COND_PL: return !n;
            COND_VS: return v;
            COND_VC: return !v;
            COND_HI: return c && !z;
            COND_LS: return !c || z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return !z && (n == v);
            COND_LE: return z || (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arm_main_decoder.sv
// Combinational instruction-field decoder: produces the raw (ungated) datapath controls.
module arm_main_decoder
    import arm_ctrl_pkg::*;
(
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       u_bit,
    output logic       alu_src,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic [3:0] alu_control,
    output logic       dp_write,
    output logic       is_branch,
    output logic       flag_w,
    output logic       is_mem,
    output logic       is_load
);

    always_comb begin
        alu_src     = 1'b0;
        imm_src     = 2'b00;
        reg_src     = 2'b00;
        alu_control = ALU_ADD;
        dp_write    = 1'b0;
        is_branch   = 1'b0;
        flag_w      = 1'b0;
        is_mem      = 1'b0;
        is_load     = 1'b0;
        case (op)
            OP_DP: begin
                alu_src = funct[5];
                // unlisted commands fall through as NOPs with no register or flag write
                case (funct[4:1])
                    CMD_ADD: begin alu_control = ALU_ADD; dp_write = 1'b1; flag_w = funct[0]; end
                    CMD_SUB: begin alu_control = ALU_SUB; dp_write = 1'b1; flag_w = funct[0]; end
                    CMD_AND: begin alu_control = ALU_AND; dp_write = 1'b1; flag_w = funct[0]; end
                    CMD_ORR: begin alu_control = ALU_ORR; dp_write = 1'b1; flag_w = funct[0]; end
                    CMD_MOV: begin alu_control = ALU_MOV; dp_write = 1'b1; flag_w = funct[0]; end
                    CMD_CMP: begin alu_control = ALU_SUB; flag_w = 1'b1; end
                    default: ;
                endcase
            end
            OP_MEM: begin
                alu_src     = 1'b1;
                imm_src     = 2'b01;
                reg_src     = 2'b10;
                alu_control = u_bit ? ALU_ADD : ALU_SUB;
                is_mem      = 1'b1;
                is_load     = funct[0];
            end
            OP_B: begin
                alu_src     = 1'b1;
                imm_src     = 2'b10;
                reg_src     = 2'b01;
                alu_control = ALU_ADD;
                is_branch   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arm_control_unit.sv
// Sequencing controller: flags register, conditional execution, and the RUN/MEM_WAIT/HALT
// FSM that freezes the PC while a data-memory access is outstanding.
module arm_control_unit
    import arm_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        PCSrc,
    output logic        MemtoReg,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [3:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        PCWrite,
    output logic        MemReq,
    output logic        halted
);

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    logic       dec_alu_src, dec_dp_write, dec_is_branch, dec_flag_w, dec_is_mem, dec_is_load;
    logic [1:0] dec_imm_src, dec_reg_src;
    logic [3:0] dec_alu_control;
    logic       cond_ex, halt_req, rd_is_pc, run_reg_write;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

    arm_main_decoder u_decoder (
        .op          (Instr[27:26]),
        .funct       (Instr[25:20]),
        .u_bit       (Instr[23]),
        .alu_src     (dec_alu_src),
        .imm_src     (dec_imm_src),
        .reg_src     (dec_reg_src),
        .alu_control (dec_alu_control),
        .dp_write    (dec_dp_write),
        .is_branch   (dec_is_branch),
        .flag_w      (dec_flag_w),
        .is_mem      (dec_is_mem),
        .is_load     (dec_is_load)
    );

    // conditions always see the flags committed by earlier instructions
    assign halt_req      = (Instr[31:28] == COND_NV);
    assign cond_ex       = cond_holds(Instr[31:28], flags_q);
    assign rd_is_pc      = (Instr[15:12] == 4'hF);
    assign run_reg_write = cond_ex && dec_dp_write;

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        wait_cnt_d = wait_cnt_q;
        PCSrc      = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrc     = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        ALUControl = 4'b0000;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        PCWrite    = 1'b0;
        MemReq     = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else begin
                        ALUSrc     = dec_alu_src;
                        ImmSrc     = dec_imm_src;
                        RegSrc     = dec_reg_src;
                        ALUControl = dec_alu_control;
                        if (dec_is_mem && cond_ex) begin
                            MemReq     = 1'b1;
                            state_d    = ST_MEM_WAIT;
                            wait_cnt_d = 8'd0;
                        end else begin
                            PCWrite  = 1'b1;
                            RegWrite = run_reg_write;
                            PCSrc    = (cond_ex && dec_is_branch) || (run_reg_write && rd_is_pc);
                            if (cond_ex && dec_flag_w) begin
                                flags_d = ALUFlags;
                            end
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    ALUSrc     = dec_alu_src;
                    ImmSrc     = dec_imm_src;
                    RegSrc     = dec_reg_src;
                    ALUControl = dec_alu_control;
                    MemReq     = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (mem_ready) begin
                        PCWrite  = 1'b1;
                        RegWrite = dec_is_load;
                        MemtoReg = dec_is_load;
                        PCSrc    = dec_is_load && rd_is_pc;
                        MemWrite = !dec_is_load;
                        state_d  = ST_RUN;
                    end else if (wait_cnt_q == WAIT_LIMIT) begin
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            flags_q    <= 4'b0000;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_arm_control_unit.sv
// Self-checking bench for arm_control_unit: directed scenarios followed by random
// instruction streams, all compared cycle by cycle against a behavioural model.
module tb_arm_control_unit;

    localparam int WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        mem_ready;
    logic        PCSrc, MemtoReg, ALUSrc, RegWrite, MemWrite;
    logic [3:0]  ALUControl;
    logic [1:0]  ImmSrc, RegSrc;
    logic        PCWrite, MemReq, halted;

    always #5 clk = ~clk;

    arm_control_unit #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .mem_ready  (mem_ready),
        .PCSrc      (PCSrc),
        .MemtoReg   (MemtoReg),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .PCWrite    (PCWrite),
        .MemReq     (MemReq),
        .halted     (halted)
    );

    int check_count = 0;
    int error_count = 0;
    int cycle_no    = 0;

    // behavioural model state: committed flags, halted, outstanding memory request and its age
    bit [3:0] m_flags   = 4'b0000;
    bit       m_halted  = 1'b0;
    bit       m_pending = 1'b0;
    int       m_age     = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mkInstr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                                            input logic [3:0] rd, input logic [3:0] rn, input logic [11:0] low);
        return {cond, op, funct, rn, rd, low};
    endfunction

    // ARM's own formulation: a base test per cond[3:1], inverted by cond[0]
    function automatic bit condPasses(input bit [3:0] cond, input bit [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = (n == v) && !z;
            default: base = 1'b1;
        endcase
        return cond[0] ? !base : base;
    endfunction

    function automatic logic [15:0] packOut(input bit pcsrc, input bit m2r, input bit asrc, input bit rw, input bit mw,
                                            input logic [3:0] alu, input logic [1:0] imm, input logic [1:0] rsrc,
                                            input bit pcw, input bit mreq, input bit hlt);
        return {pcsrc, m2r, asrc, rw, mw, alu, imm, rsrc, pcw, mreq, hlt};
    endfunction

    task automatic modelAndCheck();
        logic [15:0] expv, mask, obsv;
        bit [1:0] op;
        bit [3:0] cmd;
        bit s_bit, load, rd_pc, pass, known, writes_rd, sets_flags;
        bit e_pcsrc, e_m2r, e_asrc, e_rw, e_mw, e_pcw, e_mreq, e_hlt;
        logic [3:0] e_alu;
        logic [1:0] e_imm, e_rsrc;

        op = Instr[27:26]; cmd = Instr[24:21]; s_bit = Instr[20]; load = Instr[20];
        rd_pc = (Instr[15:12] == 4'd15);
        {e_pcsrc, e_m2r, e_asrc, e_rw, e_mw, e_pcw, e_mreq, e_hlt} = '0;
        e_alu = 4'd0; e_imm = 2'd0; e_rsrc = 2'd0;
        mask = 16'hFFFF;
        known = 1'b0; writes_rd = 1'b0; sets_flags = 1'b0;

        // what the instruction asks of the datapath, independent of FSM state
        case (op)
            2'b00: begin
                e_asrc = Instr[25];
                known = 1'b1; writes_rd = 1'b1; sets_flags = s_bit;
                if      (cmd == 4'b0100) e_alu = 4'b0000;
                else if (cmd == 4'b0010) e_alu = 4'b0001;
                else if (cmd == 4'b0000) e_alu = 4'b0010;
                else if (cmd == 4'b1100) e_alu = 4'b0011;
                else if (cmd == 4'b1101) e_alu = 4'b0100;
                else if (cmd == 4'b1010) begin e_alu = 4'b0001; writes_rd = 1'b0; sets_flags = 1'b1; end
                else begin known = 1'b0; writes_rd = 1'b0; sets_flags = 1'b0; end
                if (!known) mask &= ~16'h0780;
            end
            2'b01: begin e_asrc = 1'b1; e_imm = 2'b01; e_rsrc = 2'b10; e_alu = Instr[23] ? 4'b0000 : 4'b0001; end
            2'b10: begin e_asrc = 1'b1; e_imm = 2'b10; e_rsrc = 2'b01; e_alu = 4'b0000; end
            default: mask &= ~16'h27F8;
        endcase

        if (rst) begin
            {e_asrc, e_alu, e_imm, e_rsrc} = '0;
            mask = 16'hFFFF;
            m_halted = 1'b0; m_pending = 1'b0; m_flags = 4'b0000;
        end else if (m_halted) begin
            {e_asrc, e_alu, e_imm, e_rsrc} = '0;
            mask = 16'hFFFF;
            e_hlt = 1'b1;
        end else if (m_pending) begin
            m_age++;
            e_mreq = 1'b1;
            if (mem_ready) begin
                e_pcw = 1'b1;
                if (load) begin e_rw = 1'b1; e_m2r = 1'b1; e_pcsrc = rd_pc; end
                else e_mw = 1'b1;
                m_pending = 1'b0;
            end else if (m_age == WAIT_MAX + 1) begin
                m_pending = 1'b0;
                m_halted = 1'b1;
            end
        end else if (Instr[31:28] == 4'hF) begin
            mask = 16'h9803;
            m_halted = 1'b1;
        end else begin
            pass = condPasses(Instr[31:28], m_flags);
            if (op == 2'b01 && pass) begin
                e_mreq = 1'b1;
                m_pending = 1'b1;
                m_age = 0;
            end else begin
                e_pcw = 1'b1;
                e_rw = pass && writes_rd;
                e_pcsrc = pass && ((op == 2'b10) || (e_rw && rd_pc));
                if (pass && sets_flags) m_flags = ALUFlags;
            end
        end

        expv = packOut(e_pcsrc, e_m2r, e_asrc, e_rw, e_mw, e_alu, e_imm, e_rsrc, e_pcw, e_mreq, e_hlt);
        obsv = {PCSrc, MemtoReg, ALUSrc, RegWrite, MemWrite, ALUControl, ImmSrc, RegSrc, PCWrite, MemReq, halted};
        checkOutput($sformatf("cyc%0d instr=%h", cycle_no, Instr), {16'd0, obsv & mask}, {16'd0, expv & mask});
    endtask

    task automatic applyStimulus(input logic r, input logic [31:0] ins, input logic [3:0] fl, input logic rdy);
        @(posedge clk);
        #1;
        rst = r; Instr = ins; ALUFlags = fl; mem_ready = rdy;
        #3;
        cycle_no++;
        modelAndCheck();
    endtask

    function automatic logic [31:0] randomInstr();
        logic [3:0] cond, rd;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] cmds [6];
        int pick;
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1101};
        pick = $urandom_range(0, 99);
        cond = (pick < 50) ? 4'hE : ((pick < 99) ? 4'($urandom_range(0, 14)) : 4'hF);
        op = 2'($urandom_range(0, 3));
        funct = 6'($urandom);
        if (op == 2'b00 && $urandom_range(0, 9) != 0)
            funct[4:1] = cmds[$urandom_range(0, 5)];
        rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
        return mkInstr(cond, op, funct, rd, 4'($urandom), 12'($urandom));
    endfunction

    initial begin
        logic [31:0] adds, beq, bne, ldr, str_i, subne, cmp_i, mov_pc, halt_i, cur;
        adds   = mkInstr(4'hE, 2'b00, 6'b101001, 4'd1, 4'd0, 12'd0);
        beq    = mkInstr(4'h0, 2'b10, 6'b100000, 4'd0, 4'd0, 12'd8);
        bne    = mkInstr(4'h1, 2'b10, 6'b100000, 4'd0, 4'd0, 12'd8);
        ldr    = mkInstr(4'hE, 2'b01, 6'b011001, 4'd2, 4'd0, 12'd4);
        str_i  = mkInstr(4'hE, 2'b01, 6'b011000, 4'd2, 4'd0, 12'd4);
        subne  = mkInstr(4'h1, 2'b00, 6'b000100, 4'd1, 4'd2, 12'd3);
        cmp_i  = mkInstr(4'hE, 2'b00, 6'b010101, 4'd0, 4'd0, 12'd0);
        mov_pc = mkInstr(4'hE, 2'b00, 6'b011010, 4'd15, 4'd0, 12'd3);
        halt_i = mkInstr(4'hF, 2'b00, 6'b101000, 4'd1, 4'd0, 12'd0);

        rst = 1'b1; Instr = '0; ALUFlags = '0; mem_ready = 1'b0;
        applyStimulus(1'b1, adds, 4'b0000, 1'b0);
        applyStimulus(1'b1, ldr, 4'b1111, 1'b1);

        applyStimulus(1'b0, adds, 4'b0100, 1'b0);
        applyStimulus(1'b0, beq, 4'b0000, 1'b0);
        applyStimulus(1'b0, adds, 4'b0100, 1'b0);
        applyStimulus(1'b0, bne, 4'b0000, 1'b0);

        applyStimulus(1'b0, ldr, 4'b0000, 1'b1);
        applyStimulus(1'b0, ldr, 4'b0000, 1'b0);
        applyStimulus(1'b0, ldr, 4'b0000, 1'b0);
        applyStimulus(1'b0, ldr, 4'b0000, 1'b1);

        applyStimulus(1'b0, subne, 4'b1011, 1'b0);
        applyStimulus(1'b0, beq, 4'b0000, 1'b0);
        applyStimulus(1'b0, adds, 4'b0000, 1'b0);
        applyStimulus(1'b0, beq, 4'b0000, 1'b0);
        applyStimulus(1'b0, cmp_i, 4'b0100, 1'b0);
        applyStimulus(1'b0, beq, 4'b0000, 1'b0);
        applyStimulus(1'b0, mov_pc, 4'b0000, 1'b0);

        applyStimulus(1'b0, str_i, 4'b0000, 1'b0);
        for (int i = 0; i < WAIT_MAX + 1; i++) applyStimulus(1'b0, str_i, 4'b0000, 1'b0);
        applyStimulus(1'b0, str_i, 4'b0000, 1'b1);
        applyStimulus(1'b0, adds, 4'b0100, 1'b1);
        applyStimulus(1'b1, adds, 4'b0000, 1'b0);

        applyStimulus(1'b0, ldr, 4'b0000, 1'b0);
        for (int i = 0; i < WAIT_MAX - 1; i++) applyStimulus(1'b0, ldr, 4'b0000, 1'b0);
        applyStimulus(1'b0, ldr, 4'b0000, 1'b1);

        applyStimulus(1'b0, adds, 4'b0100, 1'b0);
        applyStimulus(1'b0, ldr, 4'b0000, 1'b0);
        applyStimulus(1'b0, ldr, 4'b0000, 1'b0);
        applyStimulus(1'b1, ldr, 4'b0000, 1'b1);
        applyStimulus(1'b0, bne, 4'b0000, 1'b0);
        applyStimulus(1'b0, beq, 4'b0000, 1'b0);

        applyStimulus(1'b0, halt_i, 4'b1111, 1'b0);
        applyStimulus(1'b0, adds, 4'b0100, 1'b0);
        applyStimulus(1'b0, mov_pc, 4'b0000, 1'b0);
        applyStimulus(1'b0, ldr, 4'b0000, 1'b1);
        applyStimulus(1'b1, adds, 4'b0000, 1'b0);

        cur = adds;
        for (int i = 0; i < 4000; i++) begin
            logic r;
            if (!m_pending) cur = randomInstr();
            r = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            applyStimulus(r, cur, 4'($urandom), ($urandom_range(0, 99) < 30));
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
